// File: rtl/state_seq_gen_pkg.sv
// Shared types and transition rules for the 4-bit state sequencer and its checker.
// Package state_seq_pkg: FSM enum, state width/count, next-hop and legal-edge functions.
package state_seq_pkg;

  localparam int STATE_W = 4;
  localparam int NUM_ST  = 8;

  typedef logic [STATE_W-1:0] st_t;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } fsm_t;

  function automatic st_t ring_next(input st_t s);
    if (s == st_t'(NUM_ST - 1)) return '0;
    return s + st_t'(1);
  endfunction

  // Targets 1 and 2 are reached faster through the 3->1 / 5->1 shortcuts.
  function automatic st_t next_hop(input st_t s, input st_t t);
    if ((t == st_t'(1) || t == st_t'(2)) && (s == st_t'(3) || s == st_t'(5)))
      return st_t'(1);
    return ring_next(s);
  endfunction

  function automatic logic legal_edge(input st_t old_s, input st_t new_s);
    if (new_s == ring_next(old_s)) return 1'b1;
    return (new_s == st_t'(1)) && (old_s == st_t'(3) || old_s == st_t'(5));
  endfunction

endpackage

// File: rtl/state_seq_gen_if.sv
// Request/status bundle between a target requester (master) and state_seq_gen (slave).
interface state_seq_gen_if;
  import state_seq_pkg::*;

  // A target transfers on a clock edge where tgt_valid && tgt_ready; the requester
  // holds tgt_valid and tgt stable until that edge.
  logic tgt_valid;
  logic tgt_ready;
  st_t  tgt;
  logic abort;
  st_t  state;
  logic busy;
  logic done;
  logic err;
  fsm_t fsm_dbg;

  modport master (
    output tgt_valid, tgt, abort,
    input  tgt_ready, state, busy, done, err, fsm_dbg
  );

  modport slave (
    input  tgt_valid, tgt, abort,
    output tgt_ready, state, busy, done, err, fsm_dbg
  );

endinterface

// File: rtl/state_seq_gen_dwell.sv
// Loadable down-counter that times how long each state value is held.
module state_seq_dwell #(
  parameter int DWELL_CYC = 4,
  localparam int CW = $clog2(DWELL_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic dec,
  output logic zero
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL_CYC - 1);

  logic [CW-1:0] cnt;

  // Decrement stops at zero so the counter can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (load)              cnt <= LOAD_VAL;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/state_seq_gen.sv
// Walks the state output toward a requested target one legal hop per DWELL_CYC clocks.
// Define STATE_SEQ_GEN_SVA_EN to compile the embedded transition assertions.
module state_seq_gen #(
  parameter int DWELL_CYC = 4,
  parameter int RESET_ST  = 0
) (
  input  logic            clk,
  input  logic            rst,
  state_seq_gen_if.slave  bus
);
  import state_seq_pkg::*;

  fsm_t fsm_q, fsm_d;
  st_t  state_q, state_d;
  st_t  tgt_q, tgt_d;
  st_t  hop;
  logic done_q, done_d;
  logic err_q, err_d;
  logic cnt_load, cnt_clr, cnt_zero;

  state_seq_dwell #(.DWELL_CYC(DWELL_CYC)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .clr  (cnt_clr),
    .dec  (fsm_q == MOVE),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= st_t'(RESET_ST);
      tgt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    tgt_d    = tgt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    hop      = next_hop(state_q, tgt_q);
    case (fsm_q)
      IDLE: begin
        if (bus.tgt_valid) begin
          if (int'(bus.tgt) >= NUM_ST) begin
            err_d = 1'b1;
          end else if (bus.tgt == state_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d    = bus.tgt;
            cnt_load = 1'b1;
            fsm_d    = MOVE;
          end
        end
      end
      MOVE: begin
        // Abort wins over a hop due on the same edge: state is frozen where it is.
        if (bus.abort) begin
          fsm_d   = IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          state_d = hop;
          if (hop == tgt_q) begin
            done_d = 1'b1;
            fsm_d  = IDLE;
          end else begin
            cnt_load = 1'b1;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign bus.tgt_ready = (fsm_q == IDLE);
  assign bus.busy      = (fsm_q == MOVE);
  assign bus.state     = state_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.fsm_dbg   = fsm_q;

`ifdef STATE_SEQ_GEN_SVA_EN
  default clocking cb @(posedge clk); endclocking
  default disable iff (rst);

  a_legal_edge: assert property ($changed(state_q) |-> legal_edge($past(state_q), state_q))
    else $error("state_seq_gen: illegal edge %0d -> %0d", $past(state_q), state_q);

  a_entry_one: assert property (($changed(state_q) && state_q == st_t'(1))
                                |-> ($past(state_q) inside {st_t'(0), st_t'(3), st_t'(5)}))
    else $error("state_seq_gen: entry to 1 from %0d -> %0d", $past(state_q), state_q);

  if (DWELL_CYC > 1) begin : g_dwell_chk
    a_dwell: assert property ($changed(state_q) |=> $stable(state_q) [* (DWELL_CYC - 1)])
      else $error("state_seq_gen: dwell too short %0d -> %0d", $past(state_q), state_q);
  end

  a_done_err: assert property (!(done_q && err_q))
    else $error("state_seq_gen: done with err, state %0d -> %0d", $past(state_q), state_q);

  a_ready_busy: assert property (bus.tgt_ready == !bus.busy)
    else $error("state_seq_gen: ready/busy clash, state %0d -> %0d", $past(state_q), state_q);
`endif

endmodule
